// File: rtl/encoder8_seq.sv
// Sequential 8-to-3 priority encoder: queues one-hot op requests and hands out one select per handshake.
// Optional build macro ENCODER8_ONEHOT_CHECK_EN rejects multi-hot request vectors and flags them on error.
module encoder8_seq #(
    parameter int HIGH_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] req,
    input  logic       out_ready,
    input  logic       clear,
    output logic [2:0] select,
    output logic       out_valid,
    output logic [7:0] pending,
    output logic       overrun,
    output logic       error
);

    function automatic logic [2:0] prio_index(input logic [7:0] mask, input logic high_first);
        logic [2:0] idx;
        idx = 3'd0;
        if (high_first) begin
            for (int i = 0; i < 8; i++) idx = mask[i] ? i[2:0] : idx;
        end else begin
            for (int i = 7; i >= 0; i--) idx = mask[i] ? i[2:0] : idx;
        end
        return idx;
    endfunction

    logic [7:0] pending_q, pending_d;
    logic [2:0] select_q, select_d;
    logic       out_valid_q, out_valid_d;
    logic       overrun_q, overrun_d;
    logic       error_q, error_d;

    logic [7:0] acc_s;
    logic [7:0] grant_onehot_s;
    logic [2:0] grant_idx_s;
    logic       free_s;
    logic       load_s;
    logic       err_set_s;
    logic       ovr_set_s;

    // Next-state: request filtering, grant selection, pending merge and sticky flags.
    always_comb begin
        acc_s     = enable ? req : 8'h00;
        err_set_s = 1'b0;
`ifdef ENCODER8_ONEHOT_CHECK_EN
        if (enable && ((req & (req - 8'd1)) != 8'h00)) begin
            acc_s     = 8'h00;
            err_set_s = 1'b1;
        end else begin
            err_set_s = 1'b0;
        end
`endif
        free_s         = !out_valid_q || out_ready;
        load_s         = free_s && (pending_q != 8'h00);
        grant_idx_s    = prio_index(pending_q, HIGH_FIRST != 0);
        grant_onehot_s = load_s ? (8'h01 << grant_idx_s) : 8'h00;
        // A re-request of the bit being granted this cycle keeps it pending.
        pending_d = (pending_q & ~grant_onehot_s) | acc_s;
        ovr_set_s = (acc_s & pending_q & ~grant_onehot_s) != 8'h00;

        if (load_s) begin
            select_d    = grant_idx_s;
            out_valid_d = 1'b1;
        end else if (free_s) begin
            select_d    = select_q;
            out_valid_d = 1'b0;
        end else begin
            select_d    = select_q;
            out_valid_d = out_valid_q;
        end

        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (clear) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

`ifdef ENCODER8_ONEHOT_CHECK_EN
        if (err_set_s) begin
            error_d = 1'b1;
        end else if (clear) begin
            error_d = 1'b0;
        end else begin
            error_d = error_q;
        end
`else
        error_d = 1'b0;
`endif
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q   <= 8'h00;
            select_q    <= 3'd0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            select_q    <= select_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            error_q     <= error_d;
        end
    end

    assign pending   = pending_q;
    assign select    = select_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign error     = error_q;

endmodule

// File: tb/tb_encoder8_seq.sv
// Bench for encoder8_seq: drives a HIGH_FIRST=1 and a HIGH_FIRST=0 instance in parallel.
module tb_encoder8_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] req = 8'h00;
    logic       out_ready = 1'b0;
    logic       clear = 1'b0;

    logic [2:0] sel_h, sel_l;
    logic       val_h, val_l, ovr_h, ovr_l, err_h, err_l;
    logic [7:0] pend_h, pend_l;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference state per instance: index 1 = highest-first, index 0 = lowest-first.
    logic [7:0] m_pend[2];
    logic [2:0] m_sel[2];
    logic       m_val[2];
    logic       m_ovr[2];
    logic       m_err[2];

    encoder8_seq #(.HIGH_FIRST(1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .out_ready(out_ready),
        .clear(clear), .select(sel_h), .out_valid(val_h), .pending(pend_h),
        .overrun(ovr_h), .error(err_h)
    );

    encoder8_seq #(.HIGH_FIRST(0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .out_ready(out_ready),
        .clear(clear), .select(sel_l), .out_valid(val_l), .pending(pend_l),
        .overrun(ovr_l), .error(err_l)
    );

    always #5 clk = ~clk;

    wire [13:0] obs_h = {val_h, sel_h, pend_h, ovr_h, err_h};
    wire [13:0] obs_l = {val_l, sel_l, pend_l, ovr_l, err_l};

    function automatic logic [13:0] exp_vec(input int m);
        return {m_val[m], m_sel[m], m_pend[m], m_ovr[m], m_err[m]};
    endfunction

    // Drive one cycle of inputs, advance the reference model, sample just after the edge.
    task automatic step(input logic rst, input logic en, input logic [7:0] rq,
                        input logic rdy, input logic clr);
        logic [7:0] n_pend[2];
        logic [2:0] n_sel[2];
        logic       n_val[2], n_ovr[2], n_err[2];
        rst_n = rst; enable = en; req = rq; out_ready = rdy; clear = clr;
        for (int m = 0; m < 2; m++) begin
            logic [7:0] acc, gm;
            logic       eset, free;
            int         g;
            acc  = en ? rq : 8'h00;
            eset = 1'b0;
`ifdef ENCODER8_ONEHOT_CHECK_EN
            if (en && $countones(rq) > 1) begin acc = 8'h00; eset = 1'b1; end
`endif
            free = !m_val[m] || rdy;
            gm   = 8'h00;
            g    = -1;
            if (free && m_pend[m] != 8'h00) begin
                if (m == 1) begin
                    for (int b = 0; b < 8; b++) if (m_pend[m][b]) g = b;
                end else begin
                    for (int b = 7; b >= 0; b--) if (m_pend[m][b]) g = b;
                end
                gm = 8'h01 << g;
            end
            n_pend[m] = (m_pend[m] & ~gm) | acc;
            n_sel[m]  = (g >= 0) ? g[2:0] : m_sel[m];
            n_val[m]  = (g >= 0) ? 1'b1 : (free ? 1'b0 : m_val[m]);
            n_ovr[m]  = ((acc & m_pend[m] & ~gm) != 8'h00) ? 1'b1 : (clr ? 1'b0 : m_ovr[m]);
            n_err[m]  = eset ? 1'b1 : (clr ? 1'b0 : m_err[m]);
            if (!rst) begin
                n_pend[m] = 8'h00; n_sel[m] = 3'd0; n_val[m] = 1'b0;
                n_ovr[m] = 1'b0; n_err[m] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = n_pend[m]; m_sel[m] = n_sel[m]; m_val[m] = n_val[m];
            m_ovr[m] = n_ovr[m]; m_err[m] = n_err[m];
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
        tests_run++;
        if (obs_h !== 14'h0 || obs_l !== 14'h0) begin
            tests_failed++;
            $display("FAIL reset: got hi=%h lo=%h required 0000", obs_h, obs_l);
        end
    endtask

    task automatic test_single();
        step(1'b1, 1'b1, 8'h04, 1'b1, 1'b0);
        tests_run++;
        if (pend_h !== 8'h04 || val_h !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_queue: got pend=%h valid=%b required pend=04 valid=0", pend_h, val_h);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if ({val_h, sel_h, pend_h} !== {1'b1, 3'd2, 8'h00} || {val_l, sel_l} !== {1'b1, 3'd2}) begin
            tests_failed++;
            $display("FAIL single_serve: got valid=%b sel=%0d pend=%h lo_sel=%0d required valid=1 sel=2 pend=00",
                     val_h, sel_h, pend_h, sel_l);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if ({val_h, sel_h, pend_h} !== {1'b0, 3'd2, 8'h00}) begin
            tests_failed++;
            $display("FAIL single_drain: got valid=%b sel=%0d pend=%h required valid=0 sel=2 pend=00",
                     val_h, sel_h, pend_h);
        end
    endtask

    task automatic test_priority();
        step(1'b1, 1'b1, 8'h82, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if ({val_h, sel_h, pend_h, val_l, sel_l, pend_l} !== {1'b1, 3'd7, 8'h02, 1'b1, 3'd1, 8'h80}) begin
            tests_failed++;
            $display("FAIL prio_first: got hi sel=%0d pend=%h lo sel=%0d pend=%h required hi 7/02 lo 1/80",
                     sel_h, pend_h, sel_l, pend_l);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if ({val_h, sel_h, pend_h, val_l, sel_l, pend_l} !== {1'b1, 3'd1, 8'h00, 1'b1, 3'd7, 8'h00}) begin
            tests_failed++;
            $display("FAIL prio_second: got hi sel=%0d lo sel=%0d required hi 1 lo 7", sel_h, sel_l);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if (val_h !== 1'b0 || val_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_idle: got valid hi=%b lo=%b required 0", val_h, val_l);
        end
    endtask

    task automatic test_overrun();
        step(1'b1, 1'b1, 8'h08, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
        tests_run++;
        if ({val_h, sel_h, pend_h, ovr_h} !== {1'b1, 3'd3, 8'h20, 1'b0}) begin
            tests_failed++;
            $display("FAIL ovr_queue: got valid=%b sel=%0d pend=%h ovr=%b required 1/3/20/0",
                     val_h, sel_h, pend_h, ovr_h);
        end
        step(1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
        tests_run++;
        if ({val_h, sel_h, pend_h, ovr_h, ovr_l} !== {1'b1, 3'd3, 8'h20, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL ovr_dup: got valid=%b sel=%0d pend=%h ovr=%b/%b required 1/3/20/1/1",
                     val_h, sel_h, pend_h, ovr_h, ovr_l);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if ({val_h, sel_h, pend_h} !== {1'b1, 3'd5, 8'h00}) begin
            tests_failed++;
            $display("FAIL ovr_serve: got valid=%b sel=%0d pend=%h required 1/5/00", val_h, sel_h, pend_h);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if ({val_h, ovr_h} !== {1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL ovr_once: got valid=%b ovr=%b required valid=0 ovr=1", val_h, ovr_h);
        end
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tests_run++;
        if (ovr_h !== 1'b0 || ovr_l !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovr_clear: got ovr=%b/%b required 0", ovr_h, ovr_l);
        end
    endtask

    task automatic test_regrant();
        step(1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h10, 1'b1, 1'b0);
        tests_run++;
        if ({val_h, sel_h, pend_h, ovr_h} !== {1'b1, 3'd4, 8'h10, 1'b0}) begin
            tests_failed++;
            $display("FAIL regrant_keep: got valid=%b sel=%0d pend=%h ovr=%b required 1/4/10/0",
                     val_h, sel_h, pend_h, ovr_h);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if ({val_h, sel_h, pend_h} !== {1'b1, 3'd4, 8'h00}) begin
            tests_failed++;
            $display("FAIL regrant_again: got valid=%b sel=%0d pend=%h required 1/4/00", val_h, sel_h, pend_h);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_onehot();
        step(1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
`ifdef ENCODER8_ONEHOT_CHECK_EN
        tests_run++;
        if ({pend_h, err_h, err_l} !== {8'h00, 1'b1, 1'b1}) begin
            tests_failed++;
            $display("FAIL onehot_reject: got pend=%h err=%b/%b required 00/1/1", pend_h, err_h, err_l);
        end
        step(1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if ({val_h, sel_h, err_h} !== {1'b1, 3'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL onehot_pass: got valid=%b sel=%0d err=%b required 1/0/1", val_h, sel_h, err_h);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        tests_run++;
        if (err_h !== 1'b0) begin
            tests_failed++;
            $display("FAIL onehot_clear: got err=%b required 0", err_h);
        end
`else
        tests_run++;
        if ({pend_h, err_h} !== {8'h11, 1'b0}) begin
            tests_failed++;
            $display("FAIL multihot_merge: got pend=%h err=%b required 11/0", pend_h, err_h);
        end
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
`endif
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if ({val_h, sel_h, pend_h, val_l, sel_l, pend_l} !== {1'b1, 3'd7, 8'h7F, 1'b1, 3'd0, 8'hFE}) begin
            tests_failed++;
            $display("FAIL full_first: got hi %b/%0d/%h lo %b/%0d/%h required hi 1/7/7f lo 1/0/fe",
                     val_h, sel_h, pend_h, val_l, sel_l, pend_l);
        end
        step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        tests_run++;
        if (obs_h !== 14'h0 || obs_l !== 14'h0) begin
            tests_failed++;
            $display("FAIL mid_reset: got hi=%h lo=%h required 0000", obs_h, obs_l);
        end
        step(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        step(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        tests_run++;
        if (obs_h !== 14'h0 || obs_l !== 14'h0) begin
            tests_failed++;
            $display("FAIL enable_off: got hi=%h lo=%h required 0000", obs_h, obs_l);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [7:0] rq;
            int         kind;
            kind = $urandom_range(0, 3);
            rq = (kind == 0) ? 8'h00 : (kind == 3) ? 8'($urandom) : (8'h01 << $urandom_range(0, 7));
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), rq,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
            tests_run++;
            if (obs_h !== exp_vec(1) || obs_l !== exp_vec(0)) begin
                tests_failed++;
                $display("FAIL random cycle %0d: got hi=%h lo=%h required hi=%h lo=%h",
                         c, obs_h, obs_l, exp_vec(1), exp_vec(0));
            end
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = 8'h00; m_sel[m] = 3'd0; m_val[m] = 1'b0; m_ovr[m] = 1'b0; m_err[m] = 1'b0;
        end
        test_reset();
        test_single();
        test_priority();
        test_overrun();
        test_regrant();
        test_onehot();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
